regfile_dual_write: RTL and testbench
=====================================

REGFILE_DUAL_WRITE -- requirements
Module: regfile_dual_write

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 The block SHALL have ports writeEnA / writeEnB, input, 1 each, write enables for write ports A and B.
REQ-006 The block SHALL have ports writeAddrA / writeAddrB, input, ADDR_WIDTH each, write addresses.
REQ-007 The block SHALL have ports writeDataA / writeDataB, input, BIT_WIDTH each, write data.
REQ-008 The block SHALL have ports readAddr1 / readAddr2, input, ADDR_WIDTH each, read addresses.
REQ-009 The block SHALL have ports readData1 / readData2, output, BIT_WIDTH each, read data.
REQ-010 The block SHALL have port ready, output, 1, meaning the clear sequence is done and the file accepts writes.

Function
REQ-011 The block SHALL implement a state machine with two states: CLEAR and RUN.
REQ-012 CLEAR SHALL hold an internal pointer clrPtr (ADDR_WIDTH bits); each cycle it SHALL write 0 to entry clrPtr and increment clrPtr.
REQ-013 After writing entry DEPTH-1, the machine SHALL go CLEAR->RUN: CLEAR lasts DEPTH-1 cycles after rst deasserts (31 for default).
REQ-014 ready SHALL be 1 only in RUN; it SHALL be registered, never combinational from rst.
REQ-015 In CLEAR, writeEnA/writeEnB SHALL be ignored and readData1/readData2 SHALL read 0.
REQ-016 In RUN, a port with its enable high and a nonzero address SHALL update that entry at the clock edge.
REQ-017 Entry 0 SHALL read 0 always; writes to address 0 SHALL be discarded.
REQ-018 If A and B are both enabled to the same nonzero address, port B SHALL win; writeDataA is discarded.
REQ-019 If A and B are enabled to different addresses, both SHALL update in the same cycle.
REQ-020 Reads SHALL be asynchronous: readDataN reflects the stored entry at readAddrN in the same cycle, with zero latency.
REQ-021 Both read ports SHALL be independent; equal read addresses SHALL return identical data.

Reset
REQ-022 When rst=1 at a clock edge: state SHALL be CLEAR, clrPtr=1, ready=0.
REQ-023 While rst=1, readData1/readData2 SHALL read 0.
REQ-024 rst asserted during CLEAR SHALL restart the sequence at clrPtr=1; rst asserted during RUN SHALL re-enter CLEAR; there are no partial-clear leftovers.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-026 With REGFILE_BYPASS_EN defined, in RUN: if readAddrN equals an enabled, nonzero write address in the same cycle, readDataN SHALL return that write's data, with B's data if both match.
REQ-027 Without REGFILE_BYPASS_EN, in that same case readDataN SHALL return the old stored value; the new value is visible the cycle after the write.
REQ-028 The bypass SHALL never apply in CLEAR, under rst, or for address 0.

Verification
REQ-029 Reset clear: rst=1 two cycles, release -> ready=0 for exactly 31 cycles, then 1; read all 32 addresses -> all 0.
REQ-030 Dual write: in RUN, A writes x5=0x11111111 and B writes x6=0x22222222 in one cycle -> next cycle readAddr1=5 gives 0x11111111 and readAddr2=6 gives 0x22222222.
REQ-031 Collision and x0: A writes x7=0xAAAA0000 and B writes x7=0x0000BBBB in one cycle -> x7 reads 0x0000BBBB; A writes x0=0xFFFFFFFF -> x0 reads 0.
REQ-032 Writes in CLEAR: writeEnA=1, x3=0x1234 during cycle 10 of CLEAR -> after ready, x3 reads 0.
REQ-033 Bypass: write x9=0xDEADBEEF with readAddr1=9 in the same cycle -> with macro, 0xDEADBEEF that cycle; without, the old value that cycle and 0xDEADBEEF the next.
REQ-034 Reset mid-run: x4=0x55 stored, then pulse rst -> x4 reads 0, ready low for 31 cycles, then high.

Source files
------------

// File: rtl/regfile_dual_write.sv
// regfile_dual_write: 2-write / 2-read register file with a self-clearing start-up sequence.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_dual_write #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEnA,
    input  logic                  writeEnB,
    input  logic [ADDR_WIDTH-1:0] writeAddrA,
    input  logic [ADDR_WIDTH-1:0] writeAddrB,
    input  logic [BIT_WIDTH-1:0]  writeDataA,
    input  logic [BIT_WIDTH-1:0]  writeDataB,
    input  logic [ADDR_WIDTH-1:0] readAddr1,
    input  logic [ADDR_WIDTH-1:0] readAddr2,
    output logic [BIT_WIDTH-1:0]  readData1,
    output logic [BIT_WIDTH-1:0]  readData2,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_CLR = ADDR_WIDTH'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_d;
    logic                  ready_q;
    logic [BIT_WIDTH-1:0]  mem_q [DEPTH];

    logic run;
    logic wr_a;
    logic wr_b;

    // Entry 0 is hardwired to zero, so the clear walk and all writes skip it.
    assign run       = (state_q == ST_RUN) && !rst;
    assign wr_a      = run && writeEnA && (writeAddrA != '0);
    assign wr_b      = run && writeEnB && (writeAddrB != '0);
    assign clr_ptr_d = clr_ptr_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= FIRST_CLR;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_d;
                    if (clr_ptr_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_ptr_q <= FIRST_CLR;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset branch; the CLEAR walk zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end
        if (wr_a) begin
            mem_q[writeAddrA] <= writeDataA;
        end
        // Issued after port A so B's value lands when both target the same entry.
        if (wr_b) begin
            mem_q[writeAddrB] <= writeDataB;
        end
    end

    function automatic logic [BIT_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [BIT_WIDTH-1:0] data;
        // NOTE: every combinational result gets a default first, so no path can infer a latch.
        data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_a && (writeAddrA == addr)) begin
            data = writeDataA;
        end
        if (wr_b && (writeAddrB == addr)) begin
            data = writeDataB;
        end
`endif
        if (!run || (addr == '0)) begin
            data = '0;
        end
        return data;
    endfunction

    always_comb begin
        readData1 = read_port(readAddr1);
        readData2 = read_port(readAddr2);
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_dual_write.sv
// Self-checking bench for regfile_dual_write: directed scenarios plus randomized traffic
// compared against an array-based reference model. Honours REGFILE_BYPASS_EN when defined.
module tb_regfile_dual_write;

    localparam int BW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          writeEnA, writeEnB;
    logic [AW-1:0] writeAddrA, writeAddrB;
    logic [BW-1:0] writeDataA, writeDataB;
    logic [AW-1:0] readAddr1, readAddr2;
    logic [BW-1:0] readData1, readData2;
    logic          ready;

    always #5 clk = ~clk;

    regfile_dual_write #(
        .BIT_WIDTH (BW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .writeEnA  (writeEnA),
        .writeEnB  (writeEnB),
        .writeAddrA(writeAddrA),
        .writeAddrB(writeAddrB),
        .writeDataA(writeDataA),
        .writeDataB(writeDataB),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .readData1 (readData1),
        .readData2 (readData2),
        .ready     (ready)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: register contents plus "cycles since reset release".
    logic [BW-1:0] model [DEPTH];
    bit            in_run = 1'b0;
    bit            known  = 1'b0;
    int            since  = 0;

    function automatic logic [BW-1:0] exp_read(input logic [AW-1:0] a);
        if (rst || !in_run || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (writeEnB && writeAddrB == a) return writeDataB;
        if (writeEnA && writeAddrA == a) return writeDataA;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        writeEnA   = 1'b0;
        writeEnB   = 1'b0;
        writeAddrA = '0;
        writeAddrB = '0;
        writeDataA = '0;
        writeDataB = '0;
    endtask

    task automatic rand_inputs(input bit narrow);
        writeEnA   = 1'($urandom_range(0, 1));
        writeEnB   = 1'($urandom_range(0, 1));
        writeAddrA = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
        writeAddrB = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
        writeDataA = $urandom();
        writeDataB = $urandom();
        readAddr1  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
        readAddr2  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH - 1));
    endtask

    // Check the current cycle against the model, then advance one clock and update the model.
    task automatic step(input string tag);
        #2;
        check({tag, ":rd1"}, readData1, exp_read(readAddr1));
        check({tag, ":rd2"}, readData2, exp_read(readAddr2));
        if (known) check({tag, ":ready"}, BW'(ready), BW'(in_run));
        @(posedge clk);
        if (rst) begin
            in_run = 1'b0;
            since  = 0;
            known  = 1'b1;
            foreach (model[i]) model[i] = '0;
        end else if (!in_run) begin
            since++;
            if (since == DEPTH - 1) in_run = 1'b1;
        end else begin
            if (writeEnA && writeAddrA != '0) model[writeAddrA] = writeDataA;
            if (writeEnB && writeAddrB != '0) model[writeAddrB] = writeDataB;
        end
        #1;
    endtask

    task automatic peek(input string tag, input logic [AW-1:0] a, input logic [BW-1:0] e);
        readAddr1 = a;
        #1;
        check(tag, readData1, e);
    endtask

    initial begin
        idle();
        readAddr1 = '0;
        readAddr2 = '0;

        // Two reset cycles with random traffic: reads must stay zero.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs(1'b0);
            step("in_reset");
        end
        rst = 1'b0;

        // Clear walk: 31 cycles with ready low; a write to x3 lands in clear cycle 10.
        for (int i = 0; i < DEPTH - 1; i++) begin
            rand_inputs(1'b0);
            if (i == 9) begin
                writeEnA   = 1'b1;
                writeAddrA = AW'(3);
                writeDataA = 32'h0000_1234;
            end
            step("clear");
        end
        idle();
        check("ready_after_clear", BW'(ready), BW'(1));
        for (int i = 0; i < DEPTH; i++) begin
            readAddr1 = AW'(i);
            readAddr2 = AW'(DEPTH - 1 - i);
            step("all_zero");
        end
        peek("x3_write_in_clear", AW'(3), '0);
        step("x3_idle");

        // Dual write to distinct entries.
        writeEnA = 1'b1; writeAddrA = AW'(5); writeDataA = 32'h1111_1111;
        writeEnB = 1'b1; writeAddrB = AW'(6); writeDataB = 32'h2222_2222;
        step("dual_wr");
        idle();
        readAddr2 = AW'(6);
        peek("dual_x5", AW'(5), 32'h1111_1111);
        check("dual_x6", readData2, 32'h2222_2222);
        step("dual_rd");

        // Same-address collision: B wins. Writes to x0 are dropped.
        writeEnA = 1'b1; writeAddrA = AW'(7); writeDataA = 32'hAAAA_0000;
        writeEnB = 1'b1; writeAddrB = AW'(7); writeDataB = 32'h0000_BBBB;
        step("collide_wr");
        idle();
        writeEnA = 1'b1; writeAddrA = '0; writeDataA = 32'hFFFF_FFFF;
        step("x0_wr");
        idle();
        peek("collide_x7", AW'(7), 32'h0000_BBBB);
        peek("x0_zero", '0, '0);
        step("collide_rd");

        // Same-cycle write and read of x9.
        writeEnA = 1'b1; writeAddrA = AW'(9); writeDataA = 32'hDEAD_BEEF;
`ifdef REGFILE_BYPASS_EN
        peek("bypass_same_cycle", AW'(9), 32'hDEAD_BEEF);
`else
        peek("no_bypass_same_cycle", AW'(9), '0);
`endif
        step("bypass_wr");
        idle();
        peek("bypass_next_cycle", AW'(9), 32'hDEAD_BEEF);
        step("bypass_rd");

        // Randomized traffic; narrow address range provokes collisions and forwarding.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(i[0]);
            step("random");
        end
        idle();

        // Reset during RUN, then again part-way through CLEAR.
        writeEnA = 1'b1; writeAddrA = AW'(4); writeDataA = 32'h0000_0055;
        step("x4_wr");
        idle();
        peek("x4_stored", AW'(4), 32'h0000_0055);
        rst = 1'b1;
        step("rst_in_run");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_inputs(1'b0);
            step("partial_clear");
        end
        rst = 1'b1;
        rand_inputs(1'b0);
        step("rst_in_clear");
        rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            rand_inputs(1'b0);
            step("reclear");
        end
        idle();
        check("ready_after_reclear", BW'(ready), BW'(1));
        peek("x4_after_reset", AW'(4), '0);
        for (int i = 0; i < DEPTH; i++) begin
            readAddr1 = AW'(i);
            readAddr2 = AW'(i);
            step("all_zero_again");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
